hazard_controller: RTL



---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_controller_fwd_select.sv | 28 ++
 rtl/hazard_controller.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding and
// ALU operand forwarding select codes.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2,
        ST_FREEZE     = 2'd3
    } state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_EX = 2'b01;
    localparam logic [1:0] FWD_WB = 2'b10;

    // Flush countdown width; FLUSH_CYCLES is at most 4, so the reload value is at most 3.
    localparam int CNT_W = 2;

endpackage

// File: rtl/hazard_controller_fwd_select.sv
// Per-operand forwarding select: compares one ID source register against the
// in-flight EX and WB destinations. EX wins over WB; x0 is never forwarded.
module fwd_select
    import hazard_pkg::*;
(
    input  logic       use_rs_i,
    input  logic [4:0] rs_i,
    input  logic       ex_v_i,
    input  logic       ex_we_i,
    input  logic [4:0] ex_rd_i,
    input  logic       wb_v_i,
    input  logic       wb_we_i,
    input  logic [4:0] wb_rd_i,
    output logic [1:0] sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (use_rs_i && (rs_i != 5'd0)) begin
            if (ex_v_i && ex_we_i && (ex_rd_i == rs_i)) begin
                sel_o = FWD_EX;
            end else if (wb_v_i && wb_we_i && (wb_rd_i == rs_i)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: EX/WB destination tracking, operand forwarding,
// load-use stall, redirect flush and memory freeze. Optional perf counters: HAZARD_PERF_EN.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int PERF_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_reg_we,
    input  logic              id_is_load,
    input  logic              ex_redirect,
    input  logic              mem_busy,
    output logic              stall_pipe,
    output logic              stall_front,
    output logic              bubble_ex,
    output logic              flush_id,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [1:0]        ctrl_state
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_load_stalls,
    output logic [PERF_W-1:0] perf_flush_cycles,
    output logic [PERF_W-1:0] perf_freeze_cycles
`endif
);

    localparam logic [CNT_W-1:0] FLUSH_RELOAD  = CNT_W'(FLUSH_CYCLES - 1);
    localparam state_e           REDIRECT_NEXT = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       ex_v_q, ex_we_q, ex_ld_q;
    logic [4:0] ex_rd_q;
    logic       wb_v_q, wb_we_q;
    logic [4:0] wb_rd_q;
    logic       load_hazard;

    fwd_select u_fwd_a (
        .use_rs_i (id_use_rs1),
        .rs_i     (id_rs1),
        .ex_v_i   (ex_v_q),
        .ex_we_i  (ex_we_q),
        .ex_rd_i  (ex_rd_q),
        .wb_v_i   (wb_v_q),
        .wb_we_i  (wb_we_q),
        .wb_rd_i  (wb_rd_q),
        .sel_o    (fwd_a_sel)
    );

    fwd_select u_fwd_b (
        .use_rs_i (id_use_rs2),
        .rs_i     (id_rs2),
        .ex_v_i   (ex_v_q),
        .ex_we_i  (ex_we_q),
        .ex_rd_i  (ex_rd_q),
        .wb_v_i   (wb_v_q),
        .wb_we_i  (wb_we_q),
        .wb_rd_i  (wb_rd_q),
        .sel_o    (fwd_b_sel)
    );

    assign load_hazard = id_valid && ex_v_q && ex_ld_q && ex_we_q && (ex_rd_q != 5'd0) &&
                         ((id_use_rs1 && (id_rs1 == ex_rd_q)) ||
                          (id_use_rs2 && (id_rs2 == ex_rd_q)));

    // RUN, LOAD_STALL and a released FREEZE all evaluate events identically; only
    // FLUSH differs. stall_pipe is only raised alone, so it masks the other enables.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_pipe  = 1'b0;
        stall_front = 1'b0;
        bubble_ex   = 1'b0;
        flush_id    = 1'b0;
        if (mem_busy) begin
            stall_pipe = 1'b1;
            state_d    = ST_FREEZE;
        end else if (ex_redirect) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
            cnt_d     = FLUSH_RELOAD;
            state_d   = REDIRECT_NEXT;
        end else if (state_q == ST_FLUSH) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
            cnt_d     = cnt_q - CNT_W'(1);
            state_d   = (cnt_q == CNT_W'(1)) ? ST_RUN : ST_FLUSH;
        end else if (load_hazard) begin
            stall_front = 1'b1;
            bubble_ex   = 1'b1;
            state_d     = ST_LOAD_STALL;
        end else begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ctrl_state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_v_q  <= 1'b0;
            ex_rd_q <= '0;
            ex_we_q <= 1'b0;
            ex_ld_q <= 1'b0;
            wb_v_q  <= 1'b0;
            wb_rd_q <= '0;
            wb_we_q <= 1'b0;
        end else if (!stall_pipe) begin
            wb_v_q  <= ex_v_q;
            wb_rd_q <= ex_rd_q;
            wb_we_q <= ex_we_q;
            if (bubble_ex) begin
                ex_v_q <= 1'b0;
            end else begin
                ex_v_q  <= id_valid;
                ex_rd_q <= id_rd;
                ex_we_q <= id_reg_we & id_valid;
                ex_ld_q <= id_is_load & id_valid;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] perf_ld_q, perf_fl_q, perf_fz_q;

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ld_q <= '0;
            perf_fl_q <= '0;
            perf_fz_q <= '0;
        end else begin
            if (stall_front && (perf_ld_q != '1)) perf_ld_q <= perf_ld_q + PERF_W'(1);
            if (flush_id && (perf_fl_q != '1))    perf_fl_q <= perf_fl_q + PERF_W'(1);
            if (stall_pipe && (perf_fz_q != '1))  perf_fz_q <= perf_fz_q + PERF_W'(1);
        end
    end

    assign perf_load_stalls   = perf_ld_q;
    assign perf_flush_cycles  = perf_fl_q;
    assign perf_freeze_cycles = perf_fz_q;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule
